// File: rtl/dbus_wb_if.sv
// Data-bus bridge from the MEM stage to a Wishbone master port: one access at a time,
// with a registered bus side, an ack timeout and a read buffer held while the pipeline is stalled.
module dbus_wb_if #(
    parameter int unsigned STALL_W = 6,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [3:0]         cpu_sel_i,
    input  logic [31:0]        cpu_data_i,
    output logic [31:0]        cpu_data_o,
    output logic               stallreq_o,
    output logic               bus_err_o,
    output logic [31:0]        wb_adr_o,
    output logic [31:0]        wb_dat_o,
    output logic [3:0]         wb_sel_o,
    output logic               wb_we_o,
    output logic               wb_stb_o,
    output logic               wb_cyc_o,
    input  logic [31:0]        wb_dat_i,
    input  logic               wb_ack_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] BUSY       = 2'd1;
    localparam logic [1:0] WAIT_STALL = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rd_buf_q, rd_buf_d;
    logic             bus_err_q, bus_err_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;

    logic stall_any;
    logic ack_hit;
    logic abort_hit;

    assign stall_any = |stall_i;
    assign ack_hit   = (state_q == BUSY) && wb_ack_i;
    // An ack arriving in the last allowed cycle wins over the timeout.
    assign abort_hit = (state_q == BUSY) && !wb_ack_i && (cnt_q == CNT_LAST);

    always_comb begin
        logic clr_bus;
        clr_bus   = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_buf_d  = rd_buf_q;
        bus_err_d = 1'b0;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;

        case (state_q)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = cpu_we_i;
                    sel_d   = cpu_sel_i;
                    adr_d   = cpu_addr_i;
                    dat_d   = cpu_data_i;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    clr_bus = 1'b1;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    clr_bus  = 1'b1;
                    rd_buf_d = '0;
                    state_d  = IDLE;
                end else if (wb_ack_i) begin
                    clr_bus  = 1'b1;
                    // Writes leave the buffer zeroed so stores never echo bus data.
                    rd_buf_d = we_q ? '0 : wb_dat_i;
                    state_d  = stall_any ? WAIT_STALL : IDLE;
                end else if (abort_hit) begin
                    clr_bus   = 1'b1;
                    rd_buf_d  = '0;
                    bus_err_d = 1'b1;
                    state_d   = stall_any ? WAIT_STALL : IDLE;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_STALL: begin
                clr_bus = 1'b1;
                if (flush_i || !stall_any) begin
                    state_d = IDLE;
                end
            end
            default: begin
                clr_bus = 1'b1;
                state_d = IDLE;
            end
        endcase

        if (clr_bus) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            we_d  = 1'b0;
            sel_d = '0;
            adr_d = '0;
            dat_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_buf_q  <= '0;
            bus_err_q <= 1'b0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_buf_q  <= rd_buf_d;
            bus_err_q <= bus_err_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        if (!rst) begin
            stallreq_o = ((state_q == IDLE) && cpu_ce_i && !flush_i) ||
                         ((state_q == BUSY) && !wb_ack_i && !abort_hit);
            if (ack_hit && !we_q) begin
                cpu_data_o = wb_dat_i;
            end else if (state_q == WAIT_STALL) begin
                cpu_data_o = rd_buf_q;
            end
        end
    end

    assign bus_err_o = bus_err_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_dbus_wb_if.sv
// Scoreboard bench for dbus_wb_if: directed cycles push hand-computed outputs, a negedge
// monitor pops and compares them against the DUT.
module tb_dbus_wb_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    typedef struct packed {
        logic        sreq;
        logic        err;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] cpu;
    } exp_t;

    typedef struct {
        logic [63:0] tag;
        exp_t        v;
    } item_t;

    item_t sb[$];
    item_t mon_it;
    exp_t  mon_act;
    int    checks = 0;
    int    errors = 0;

    dbus_wb_if #(
        .STALL_W(6),
        .TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .cpu_ce_i  (cpu_ce_i),
        .cpu_we_i  (cpu_we_i),
        .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i (cpu_sel_i),
        .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o),
        .bus_err_o (bus_err_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i)
    );

    always #5 clk = ~clk;

    // Expected outputs for the cycle whose inputs are currently applied; stb is expected equal to cyc.
    task automatic row(input logic [63:0] tag, input logic s, input logic er, input logic c,
                       input logic w, input logic [3:0] sl, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] cp);
        item_t it;
        it.tag = tag;
        it.v   = {s, er, c, c, w, sl, a, d, cp};
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_it  = sb.pop_front();
            mon_act = {stallreq_o, bus_err_o, wb_cyc_o, wb_stb_o, wb_we_o,
                       wb_sel_o, wb_adr_o, wb_dat_o, cpu_data_o};
            checks++;
            if (mon_act !== mon_it.v) begin
                errors++;
                $display("FAIL %s: got sreq=%b err=%b cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h cpu=%h, expected sreq=%b err=%b cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h cpu=%h",
                         mon_it.tag, mon_act.sreq, mon_act.err, mon_act.cyc, mon_act.stb, mon_act.we,
                         mon_act.sel, mon_act.adr, mon_act.dat, mon_act.cpu,
                         mon_it.v.sreq, mon_it.v.err, mon_it.v.cyc, mon_it.v.stb, mon_it.v.we,
                         mon_it.v.sel, mon_it.v.adr, mon_it.v.dat, mon_it.v.cpu);
            end
        end
    end

    initial begin
        rst = 1'b1; stall_i = '0; flush_i = 1'b0;
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
        wb_dat_i = 32'hFFFF_FFFF; wb_ack_i = 1'b1;
        @(posedge clk);
        #1;
        row("RST_HOLD", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0; cpu_ce_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0;
        row("RST_IDLE", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);

        // read, ack in the third BUSY cycle
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10; cpu_sel_i = 4'hF; cpu_data_i = '0;
        row("RD_REQ__", 1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        row("RD_BUSY1", 1, 0, 1, 0, 4'hF, 32'h10, 32'h0, 32'h0);
        row("RD_BUSY2", 1, 0, 1, 0, 4'hF, 32'h10, 32'h0, 32'h0);
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        row("RD_ACK__", 0, 0, 1, 0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF);
        wb_ack_i = 1'b0; cpu_ce_i = 1'b0;
        row("RD_DONE_", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);

        // write, ack in the first BUSY cycle
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h20; cpu_sel_i = 4'h3; cpu_data_i = 32'h1234_5678;
        row("WR_REQ__", 1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
        row("WR_ACK__", 0, 0, 1, 1, 4'h3, 32'h20, 32'h1234_5678, 32'h0);
        wb_ack_i = 1'b0; cpu_ce_i = 1'b0;
        row("WR_DONE_", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);

        // ack while the pipeline is stalled
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40; cpu_sel_i = 4'hF; cpu_data_i = '0;
        row("ST_REQ__", 1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_A5A5; stall_i = 6'h3F;
        row("ST_ACK__", 0, 0, 1, 0, 4'hF, 32'h40, 32'h0, 32'hA5A5_A5A5);
        wb_ack_i = 1'b0; wb_dat_i = '0;
        row("ST_WAIT1", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'hA5A5_A5A5);
        row("ST_WAIT2", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'hA5A5_A5A5);
        stall_i = '0; cpu_ce_i = 1'b0;
        row("ST_WAIT3", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'hA5A5_A5A5);
        row("ST_IDLE_", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);

        // flush in the second BUSY cycle, then a late ack, then flush blocking a request
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h80; cpu_sel_i = 4'hF;
        row("FL_REQ__", 1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        row("FL_BUSY1", 1, 0, 1, 0, 4'hF, 32'h80, 32'h0, 32'h0);
        flush_i = 1'b1;
        row("FL_FLUSH", 1, 0, 1, 0, 4'hF, 32'h80, 32'h0, 32'h0);
        flush_i = 1'b0; cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777;
        row("FL_LATE_", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        wb_ack_i = 1'b0;
        row("FL_IDLE_", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        cpu_ce_i = 1'b1; flush_i = 1'b1;
        row("FL_IDLCE", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        cpu_ce_i = 1'b0; flush_i = 1'b0;
        row("FL_NOREQ", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);

        // timeout: abort in the 4th BUSY cycle, error pulse the cycle after
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h100;
        row("TO_REQ__", 1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        row("TO_BUSY1", 1, 0, 1, 0, 4'hF, 32'h100, 32'h0, 32'h0);
        row("TO_BUSY2", 1, 0, 1, 0, 4'hF, 32'h100, 32'h0, 32'h0);
        row("TO_BUSY3", 1, 0, 1, 0, 4'hF, 32'h100, 32'h0, 32'h0);
        row("TO_ABORT", 0, 0, 1, 0, 4'hF, 32'h100, 32'h0, 32'h0);
        cpu_ce_i = 1'b0;
        row("TO_ERR__", 0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        row("TO_ERR0_", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);

        // ack coinciding with the abort cycle, stall pending
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h200;
        row("AA_REQ__", 1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        row("AA_BUSY1", 1, 0, 1, 0, 4'hF, 32'h200, 32'h0, 32'h0);
        row("AA_BUSY2", 1, 0, 1, 0, 4'hF, 32'h200, 32'h0, 32'h0);
        row("AA_BUSY3", 1, 0, 1, 0, 4'hF, 32'h200, 32'h0, 32'h0);
        wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_CAFE; stall_i = 6'h20;
        row("AA_ACK__", 0, 0, 1, 0, 4'hF, 32'h200, 32'h0, 32'h0BAD_CAFE);
        wb_ack_i = 1'b0; wb_dat_i = '0; cpu_ce_i = 1'b0;
        row("AA_WAIT1", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0BAD_CAFE);
        stall_i = '0;
        row("AA_WAIT2", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0BAD_CAFE);
        row("AA_IDLE_", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);

        // reset during a write, late ack ignored, next read proceeds
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h300; cpu_data_i = 32'h55AA_55AA; cpu_sel_i = 4'hF;
        row("RS_REQ__", 1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        row("RS_BUSY1", 1, 0, 1, 1, 4'hF, 32'h300, 32'h55AA_55AA, 32'h0);
        rst = 1'b1;
        row("RS_RST__", 0, 0, 1, 1, 4'hF, 32'h300, 32'h55AA_55AA, 32'h0);
        rst = 1'b0; cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h9999_9999;
        row("RS_LATE_", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        wb_ack_i = 1'b0; cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h400; cpu_data_i = '0;
        row("RS_REQ2_", 1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        wb_ack_i = 1'b1; wb_dat_i = 32'h1357_9BDF;
        row("RS_ACK2_", 0, 0, 1, 0, 4'hF, 32'h400, 32'h0, 32'h1357_9BDF);
        wb_ack_i = 1'b0; cpu_ce_i = 1'b0;
        row("RS_DONE_", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);

        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
